vreg_group_file: RTL and testbench
==================================

Name: vreg_group_file

Overview:
- Parametrised successor to the 4-lane, 32-bit vector register file.
- Generic VLEN/lane count/ELEN, with an internal beat sequencer that streams a whole register group (LMUL ≥ 1, any vl) to the PEs over multiple cycles through a valid/ready handshake.
- Accepts per-beat writeback from the PE pipeline with byte-accurate lane masking and write-to-read bypass.
- Sits between the decode/issue stage and the PE array.

Parameters:
- VLEN, 32, bits per vector register (power of 2, ≥ ELEN).
- NLANES, 4, elements delivered per beat (= number of PEs).
- ELEN, 32, max element width and width of each lane slot.
- NREGS, 32, architectural vector registers.
- VL_W, $clog2(VLEN)+1, width of vl fields.

Ports:
- clk  in  1  clock
- n_reset  in  1  asynchronous active-low reset
- req_valid  in  1  new operation request
- req_ready  out  1  sequencer idle, request accepted this cycle
- req_vs1, req_vs2, req_vd  in  5 each  base register of each operand group (vd also sources vs3)
- req_vsew  in  2  0=8b, 1=16b, 2=32b for vs1/vs2; 3 is illegal
- req_vs3_sew  in  2  element width used for the vs3 read (callers pass 2×SEW for widening ops)
- req_vl  in  VL_W  element count
- rd_valid  out  1  beat data valid
- rd_ready  in  1  PE array accepts beat
- rd_vs1, rd_vs2, rd_vs3  out  NLANES*ELEN each  lane-aligned operand data
- rd_lane_mask  out  NLANES  lanes holding real elements
- rd_last  out  1  final beat of the group
- wb_valid  in  1  writeback beat (always accepted)
- wb_vd  in  5  base destination register
- wb_beat  in  VL_W  beat index within the group
- wb_sew  in  2  destination element width
- wb_lane_mask  in  NLANES  lanes to write
- wb_data  in  NLANES*ELEN  lane-aligned results; low SEW bits of each slot are used

Behaviour:
- Reset:
  - All registers clear to 0.
  - req_ready=1; rd_valid=0; rd_last=0; rd_lane_mask=0; all rd data 0.
  - Reset mid-group abandons the group immediately.
- Element addressing:
  - Element e of a group with base b at width S lives in register (b + e/(VLEN/S)) mod NREGS, bits [(e mod (VLEN/S))*S +: S].
  - A beat may straddle registers.
- FSM states IDLE, STREAM:
  - IDLE: req_ready=1.
  - On req_valid, latch the request and compute nbeats = ceil(vl/NLANES).
  - vl=0: stay IDLE, no beat produced.
  - Otherwise go to STREAM; beat 0 is registered so rd_valid=1 at T+1.
- STREAM:
  - Output register is held stable while rd_valid & !rd_ready.
  - On handshake, load the next beat the same cycle (zero-bubble).
  - On handshake with rd_last=1, clear rd_valid and return to IDLE; req_ready=1 in that next cycle.
  - req_ready=0 throughout STREAM.
- Lane formatting:
  - Each lane is zero-extended from its operand's width to ELEN.
  - rd_lane_mask bit i = (beat*NLANES + i < vl).
  - Masked-off lanes read 0.
  - rd_last = (beat == nbeats-1).
- Writeback:
  - Lane i writes element wb_beat*NLANES+i of group wb_vd at width wb_sew when wb_lane_mask[i]=1.
  - Byte enables cover only that element's bytes.
  - No write occurs when wb_vd==0 (v0 is reserved for the mask).
- Bypass:
  - When a beat is loaded into the output register in the same cycle as a writeback, written bytes are seen new (write-first).
  - A beat already held in the output register is a snapshot and is not updated by later writes.
- Illegal SEW:
  - SEW=3 or SEW>ELEN on a request is treated as vl=0.
  - The same on a writeback suppresses the write.
- Register index arithmetic wraps mod NREGS.

Optional Feature:
- Macro: VREG_SIGN_EXT_EN.
- Defined: each rd lane is sign-extended from its element width to ELEN.
- Undefined: zero-extension as above.
- Writeback is unaffected either way.

Test Plan:
- Reset with writes pending -> all outputs 0, req_ready=1; read of v5 after reset returns 0.
- Preload v2=0x44332211, v3=0x88776655; request vs1=2, sew=8b, vl=6, rd_ready=1 ->
  - beat0 rd_vs1 lanes = 0x11, 0x22, 0x33, 0x44, mask=1111, rd_last=0;
  - beat1 lanes = 0x55, 0x66, 0, 0, mask=0011, rd_last=1;
  - req_ready=1 the following cycle.
- sew=32b, vl=4, base v8, rd_ready low for 3 cycles -> rd_vs1 = {v11, v10, v9, v8} held unchanged, rd_valid=1 throughout, no beat skipped.
- wb_vd=4, wb_sew=16b, wb_beat=1, mask=0101, data lanes 0xAAAA/0xBBBB -> v6[15:0]=0xAAAA, v7[15:0]=0xBBBB; other bytes unchanged.
- wb_vd=0 with all lanes enabled -> v0 unchanged.
- Writeback to v2 byte0 in the same cycle beat0 of v2 is loaded -> rd lane 0 shows the new byte.
- With VREG_SIGN_EXT_EN, byte 0x80 is read as 0xFFFFFF80.

Source files
------------

// File: rtl/vreg_group_if.sv
// vreg_group_if: request, beat-stream and writeback bundle between issue/PE side (master) and vreg_group_file (slave).
interface vreg_group_if #(parameter int NLANES = 4, parameter int ELEN = 32, parameter int VL_W = 6);
  logic req_valid, req_ready;
  logic [4:0] req_vs1, req_vs2, req_vd;
  logic [1:0] req_vsew, req_vs3_sew;
  logic [VL_W-1:0] req_vl;
  logic rd_valid, rd_ready, rd_last;
  logic [NLANES*ELEN-1:0] rd_vs1, rd_vs2, rd_vs3;
  logic [NLANES-1:0] rd_lane_mask;
  logic wb_valid;
  logic [4:0] wb_vd;
  logic [VL_W-1:0] wb_beat;
  logic [1:0] wb_sew;
  logic [NLANES-1:0] wb_lane_mask;
  logic [NLANES*ELEN-1:0] wb_data;
  modport master(
    output req_valid, req_vs1, req_vs2, req_vd, req_vsew, req_vs3_sew, req_vl, rd_ready,
           wb_valid, wb_vd, wb_beat, wb_sew, wb_lane_mask, wb_data,
    input  req_ready, rd_valid, rd_last, rd_vs1, rd_vs2, rd_vs3, rd_lane_mask
  );
  modport slave(
    input  req_valid, req_vs1, req_vs2, req_vd, req_vsew, req_vs3_sew, req_vl, rd_ready,
           wb_valid, wb_vd, wb_beat, wb_sew, wb_lane_mask, wb_data,
    output req_ready, rd_valid, rd_last, rd_vs1, rd_vs2, rd_vs3, rd_lane_mask
  );
endinterface

// File: rtl/vreg_group_file.sv
// vreg_group_file: vector register file streaming LMUL groups to the PE array beat by beat, with masked writeback and write-first bypass.
// Define VREG_SIGN_EXT_EN to sign-extend read lanes instead of zero-extending them.
module vreg_group_file #(
  parameter int VLEN = 32,
  parameter int NLANES = 4,
  parameter int ELEN = 32,
  parameter int NREGS = 32,
  parameter int VL_W = $clog2(VLEN) + 1
) (
  input logic clk,
  input logic n_reset,
  vreg_group_if.slave bus
);
  typedef enum logic {IDLE, STREAM} state_t;
  localparam int EPB = ELEN / 8;
  localparam int RW = $clog2(NREGS);
  localparam int BW = $clog2(VLEN / 8);
  state_t state, state_n;
  logic [VLEN-1:0] regs [NREGS];
  logic [VLEN-1:0] regs_n [NREGS];
  logic [4:0] vs1_q, vs2_q, vd_q, s_vs1, s_vs2, s_vd;
  logic [1:0] sew_q, sew3_q, s_sew, s_sew3;
  logic [VL_W-1:0] vl_q, beat_q, nbeats_q, s_vl, s_beat, s_nb;
  logic [NLANES*ELEN-1:0] l_vs1, l_vs2, l_vs3;
  logic [NLANES-1:0] l_mask;
  logic load, done;
  function automatic logic sew_ok(input logic [1:0] s);
    return s != 2'd3 && (8 << s) <= ELEN;
  endfunction
  function automatic logic [RW-1:0] reg_of(input logic [4:0] b, input int e, input logic [1:0] s);
    return RW'((int'(b) + e / (VLEN >> (3 + s))) % NREGS);
  endfunction
  function automatic logic [BW-1:0] byte_of(input int e, input logic [1:0] s);
    return BW'((e % (VLEN >> (3 + s))) << s);
  endfunction
  function automatic logic [ELEN-1:0] fmt(input logic [VLEN-1:0] v, input logic [BW-1:0] bo, input logic [1:0] s);
    logic [ELEN-1:0] r;
    r = '0;
    for (int k = 0; k < EPB; k++)
      if (k < (1 << s)) r[8*k +: 8] = v[{bo + BW'(k), 3'b000} +: 8];
`ifdef VREG_SIGN_EXT_EN
    for (int k = 0; k < EPB; k++)
      if (k >= (1 << s)) r[8*k +: 8] = {8{r[(8 << s) - 1]}};
`endif
    return r;
  endfunction
  // Writes are folded in combinationally so a beat loaded this cycle sees them.
  always_comb begin
    regs_n = regs;
    if (bus.wb_valid && bus.wb_vd != 5'd0 && sew_ok(bus.wb_sew))
      for (int i = 0; i < NLANES; i++)
        if (bus.wb_lane_mask[i])
          for (int k = 0; k < EPB; k++)
            if (k < (1 << bus.wb_sew))
              regs_n[reg_of(bus.wb_vd, int'(bus.wb_beat) * NLANES + i, bus.wb_sew)]
                    [{byte_of(int'(bus.wb_beat) * NLANES + i, bus.wb_sew) + BW'(k), 3'b000} +: 8]
                = bus.wb_data[i*ELEN + 8*k +: 8];
  end
  always_comb begin
    state_n = state;
    load = 1'b0;
    done = 1'b0;
    s_vs1 = state == IDLE ? bus.req_vs1 : vs1_q;
    s_vs2 = state == IDLE ? bus.req_vs2 : vs2_q;
    s_vd = state == IDLE ? bus.req_vd : vd_q;
    s_sew = state == IDLE ? bus.req_vsew : sew_q;
    s_sew3 = state == IDLE ? bus.req_vs3_sew : sew3_q;
    s_vl = state == IDLE ? bus.req_vl : vl_q;
    s_beat = state == IDLE ? '0 : beat_q + 1'b1;
    s_nb = state == IDLE ? VL_W'((int'(bus.req_vl) + NLANES - 1) / NLANES) : nbeats_q;
    if (state == IDLE) begin
      if (bus.req_valid && bus.req_vl != '0 && sew_ok(bus.req_vsew)) begin
        load = 1'b1;
        state_n = STREAM;
      end
    end else if (bus.rd_ready) begin
      done = bus.rd_last;
      load = !bus.rd_last;
      state_n = bus.rd_last ? IDLE : STREAM;
    end
  end
  always_comb begin
    l_vs1 = '0;
    l_vs2 = '0;
    l_vs3 = '0;
    l_mask = '0;
    for (int i = 0; i < NLANES; i++) begin
      l_mask[i] = int'(s_beat) * NLANES + i < int'(s_vl);
      if (l_mask[i]) begin
        l_vs1[i*ELEN +: ELEN] = fmt(regs_n[reg_of(s_vs1, int'(s_beat) * NLANES + i, s_sew)],
                                    byte_of(int'(s_beat) * NLANES + i, s_sew), s_sew);
        l_vs2[i*ELEN +: ELEN] = fmt(regs_n[reg_of(s_vs2, int'(s_beat) * NLANES + i, s_sew)],
                                    byte_of(int'(s_beat) * NLANES + i, s_sew), s_sew);
        if (sew_ok(s_sew3))
          l_vs3[i*ELEN +: ELEN] = fmt(regs_n[reg_of(s_vd, int'(s_beat) * NLANES + i, s_sew3)],
                                      byte_of(int'(s_beat) * NLANES + i, s_sew3), s_sew3);
      end
    end
  end
  assign bus.req_ready = state == IDLE;
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      state <= IDLE;
      regs <= '{default: '0};
      {vs1_q, vs2_q, vd_q, sew_q, sew3_q, vl_q, beat_q, nbeats_q} <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_last <= 1'b0;
      bus.rd_lane_mask <= '0;
      bus.rd_vs1 <= '0;
      bus.rd_vs2 <= '0;
      bus.rd_vs3 <= '0;
    end else begin
      state <= state_n;
      regs <= regs_n;
      if (load) begin
        {vs1_q, vs2_q, vd_q, sew_q, sew3_q} <= {s_vs1, s_vs2, s_vd, s_sew, s_sew3};
        {vl_q, beat_q, nbeats_q} <= {s_vl, s_beat, s_nb};
        bus.rd_valid <= 1'b1;
        bus.rd_last <= s_beat == s_nb - 1'b1;
        bus.rd_lane_mask <= l_mask;
        bus.rd_vs1 <= l_vs1;
        bus.rd_vs2 <= l_vs2;
        bus.rd_vs3 <= l_vs3;
      end else if (done) begin
        bus.rd_valid <= 1'b0;
        bus.rd_last <= 1'b0;
        bus.rd_lane_mask <= '0;
        bus.rd_vs1 <= '0;
        bus.rd_vs2 <= '0;
        bus.rd_vs3 <= '0;
      end
    end
endmodule

// File: tb/tb_vreg_group_file.sv
// tb_vreg_group_file: directed stimulus with a beat scoreboard for vreg_group_file (VLEN=32, 4 lanes, ELEN=32).
module tb_vreg_group_file;
  logic clk, n_reset;
  int checks = 0, failures = 0;
  typedef struct packed {
    logic [127:0] vs1, vs2, vs3;
    logic [3:0] mask;
    logic last;
  } beat_t;
  beat_t q[$];
`ifdef VREG_SIGN_EXT_EN
  localparam logic [31:0] B80 = 32'hFFFF_FF80;
`else
  localparam logic [31:0] B80 = 32'h0000_0080;
`endif
  vreg_group_if bus();
  vreg_group_file dut(.clk(clk), .n_reset(n_reset), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  function automatic logic [127:0] lanes(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction
  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask
  task automatic push(input logic [127:0] v1, input logic [127:0] v3, input logic [3:0] m, input logic l);
    beat_t b;
    b.vs1 = v1;
    b.vs2 = v1;
    b.vs3 = v3;
    b.mask = m;
    b.last = l;
    q.push_back(b);
  endtask
  task automatic set_req(input logic [4:0] r, input logic [1:0] s, input logic [1:0] s3, input logic [5:0] vl);
    bus.req_vs1 = r;
    bus.req_vs2 = r;
    bus.req_vd = r;
    bus.req_vsew = s;
    bus.req_vs3_sew = s3;
    bus.req_vl = vl;
    bus.req_valid = 1'b1;
  endtask
  task automatic set_wb(input logic [4:0] vd, input logic [5:0] beat, input logic [1:0] s, input logic [3:0] m, input logic [127:0] d);
    bus.wb_vd = vd;
    bus.wb_beat = beat;
    bus.wb_sew = s;
    bus.wb_lane_mask = m;
    bus.wb_data = d;
    bus.wb_valid = 1'b1;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.wb_valid = 1'b0;
  endtask
  task automatic req(input logic [4:0] r, input logic [1:0] s, input logic [1:0] s3, input logic [5:0] vl);
    set_req(r, s, s3, vl);
    step();
  endtask
  task automatic wb(input logic [4:0] vd, input logic [5:0] beat, input logic [1:0] s, input logic [3:0] m, input logic [127:0] d);
    set_wb(vd, beat, s, m, d);
    step();
  endtask
  task automatic wait_idle;
    int n = 0;
    while (!(bus.req_ready && !bus.rd_valid && q.size() == 0) && n < 200) begin
      step();
      n++;
    end
    chk("idle_timeout", 128'(n < 200), 128'(1));
  endtask
  always @(negedge clk)
    if (n_reset && bus.rd_valid && bus.rd_ready) begin
      if (q.size() == 0) chk("unexpected_beat", 128'(bus.rd_valid), 128'(0));
      else begin
        beat_t e;
        e = q.pop_front();
        chk("rd_vs1", bus.rd_vs1, e.vs1);
        chk("rd_vs2", bus.rd_vs2, e.vs2);
        chk("rd_vs3", bus.rd_vs3, e.vs3);
        chk("mask_last", 128'({bus.rd_lane_mask, bus.rd_last}), 128'({e.mask, e.last}));
      end
    end
  initial begin
    n_reset = 1'b0;
    bus.req_valid = 1'b0;
    bus.rd_ready = 1'b1;
    set_req(5'd0, 2'd0, 2'd0, 6'd0);
    bus.req_valid = 1'b0;
    set_wb(5'd5, 6'd0, 2'd2, 4'hF, {128{1'b1}});
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 128'(bus.req_ready), 128'(1));
    chk("rst_rd_flags", 128'({bus.rd_valid, bus.rd_last, bus.rd_lane_mask}), 128'(0));
    chk("rst_rd_data", bus.rd_vs1 | bus.rd_vs2 | bus.rd_vs3, 128'(0));
    bus.wb_valid = 1'b0;
    #2 n_reset = 1'b1;
    step();
    // v5 was targeted while in reset: must read back 0
    push(lanes(0, 0, 0, 0), lanes(0, 0, 0, 0), 4'b0001, 1'b1);
    req(5'd5, 2'd2, 2'd2, 6'd1);
    wait_idle();
    // byte group over v2/v3, vs3 read at 16b
    wb(5'd2, 6'd0, 2'd2, 4'b0011, lanes(32'h4433_2211, 32'h8877_6655, 32'hDEAD_0000, 32'hBEEF_0000));
    push(lanes(32'h11, 32'h22, 32'h33, 32'h44), lanes(32'h2211, 32'h4433, 32'h6655, 32'h8877), 4'b1111, 1'b0);
    push(lanes(32'h55, 32'h66, 0, 0), lanes(0, 0, 0, 0), 4'b0011, 1'b1);
    req(5'd2, 2'd0, 2'd1, 6'd6);
    chk("stream_req_ready", 128'(bus.req_ready), 128'(0));
    step();
    step();
    chk("after_last_req_ready", 128'(bus.req_ready), 128'(1));
    chk("after_last_rd_valid", 128'(bus.rd_valid), 128'(0));
    wait_idle();
    // 32b group v8..v11 held under backpressure
    wb(5'd8, 6'd0, 2'd2, 4'hF, lanes(32'h1111_0008, 32'h2222_0009, 32'h3333_000A, 32'h4444_000B));
    push(lanes(32'h1111_0008, 32'h2222_0009, 32'h3333_000A, 32'h4444_000B),
         lanes(32'h1111_0008, 32'h2222_0009, 32'h3333_000A, 32'h4444_000B), 4'hF, 1'b1);
    bus.rd_ready = 1'b0;
    req(5'd8, 2'd2, 2'd2, 6'd4);
    for (int i = 0; i < 3; i++) begin
      chk("stall_rd_valid", 128'(bus.rd_valid), 128'(1));
      chk("stall_rd_vs1", bus.rd_vs1, lanes(32'h1111_0008, 32'h2222_0009, 32'h3333_000A, 32'h4444_000B));
      step();
    end
    bus.rd_ready = 1'b1;
    wait_idle();
    // 16b masked writeback, beat 1 of group v4 lands in v6/v7 low halves
    wb(5'd6, 6'd0, 2'd2, 4'b0011, lanes(32'h1234_5678, 32'h9ABC_DEF0, 0, 0));
    wb(5'd4, 6'd1, 2'd1, 4'b0101, lanes(32'hFFFF_AAAA, 32'h0000_CCCC, 32'hFFFF_BBBB, 32'h0000_DDDD));
    push(lanes(32'h1234_AAAA, 32'h9ABC_BBBB, 0, 0), lanes(32'h1234_AAAA, 32'h9ABC_BBBB, 0, 0), 4'b0011, 1'b1);
    req(5'd6, 2'd2, 2'd2, 6'd2);
    wait_idle();
    // v0 is never written
    wb(5'd0, 6'd0, 2'd2, 4'hF, {4{32'hDEAD_BEEF}});
    push(lanes(0, 0, 32'h4433_2211, 32'h8877_6655), lanes(0, 0, 32'h4433_2211, 32'h8877_6655), 4'hF, 1'b1);
    req(5'd0, 2'd2, 2'd2, 6'd4);
    wait_idle();
    // write-first on load, then a snapshot that ignores a later write
    bus.rd_ready = 1'b0;
    push(lanes(32'h5A, 32'h22, 32'h33, 32'h44), lanes(32'h5A, 32'h22, 32'h33, 32'h44), 4'hF, 1'b1);
    set_req(5'd2, 2'd0, 2'd0, 6'd4);
    set_wb(5'd2, 6'd0, 2'd0, 4'b0001, lanes(32'h5A, 0, 0, 0));
    step();
    wb(5'd2, 6'd0, 2'd0, 4'b0010, lanes(0, 32'h77, 0, 0));
    chk("snapshot_rd_vs1", bus.rd_vs1, lanes(32'h5A, 32'h22, 32'h33, 32'h44));
    bus.rd_ready = 1'b1;
    wait_idle();
    push(lanes(32'h5A, 32'h77, 32'h33, 32'h44), lanes(32'h5A, 32'h77, 32'h33, 32'h44), 4'hF, 1'b1);
    req(5'd2, 2'd0, 2'd0, 6'd4);
    wait_idle();
    // illegal SEW and vl=0 produce nothing; illegal-SEW writeback is dropped
    wb(5'd3, 6'd0, 2'd3, 4'hF, {128{1'b1}});
    req(5'd3, 2'd3, 2'd2, 6'd4);
    chk("illegal_sew_ready", 128'({bus.req_ready, bus.rd_valid}), 128'(2'b10));
    req(5'd3, 2'd2, 2'd2, 6'd0);
    chk("vl0_ready", 128'({bus.req_ready, bus.rd_valid}), 128'(2'b10));
    step();
    chk("vl0_no_beat", 128'(bus.rd_valid), 128'(0));
    push(lanes(32'h8877_6655, 0, 0, 0), lanes(32'h8877_6655, 0, 0, 0), 4'b0001, 1'b1);
    req(5'd3, 2'd2, 2'd2, 6'd1);
    wait_idle();
    // lane extension of a negative byte
    wb(5'd12, 6'd0, 2'd0, 4'b0001, lanes(32'h80, 0, 0, 0));
    push(lanes(B80, 0, 0, 0), lanes(B80, 0, 0, 0), 4'b0001, 1'b1);
    req(5'd12, 2'd0, 2'd0, 6'd1);
    wait_idle();
    // group base wraps from v31 to v0
    wb(5'd31, 6'd0, 2'd2, 4'b0001, lanes(32'h3131_3131, 0, 0, 0));
    push(lanes(32'h3131_3131, 0, 0, 0), lanes(32'h3131_3131, 0, 0, 0), 4'b0011, 1'b1);
    req(5'd31, 2'd2, 2'd2, 6'd2);
    wait_idle();
    // reset mid-group abandons the beat and clears the file
    bus.rd_ready = 1'b0;
    req(5'd2, 2'd2, 2'd2, 6'd1);
    chk("pre_reset_valid", 128'(bus.rd_valid), 128'(1));
    n_reset = 1'b0;
    #1;
    chk("midrst_flags", 128'({bus.req_ready, bus.rd_valid, bus.rd_last, bus.rd_lane_mask}), 128'(7'b1000000));
    chk("midrst_data", bus.rd_vs1, 128'(0));
    step();
    n_reset = 1'b1;
    bus.rd_ready = 1'b1;
    step();
    push(lanes(0, 0, 0, 0), lanes(0, 0, 0, 0), 4'b0001, 1'b1);
    req(5'd2, 2'd2, 2'd2, 6'd1);
    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
